// File: rtl/accumulator_binary_saturating_multichannel_if.sv
// Command/result bundle for the multi-channel saturating accumulator.
// The slave modport is the accumulator; master is whoever issues commands
// and consumes results.
interface accumulator_binary_saturating_multichannel_if #(
   parameter int WORD_WIDTH         = 16,
   parameter int CHANNEL_COUNT      = 4,
   parameter int CHANNEL_ADDR_WIDTH = 2
) ();
   logic signed [WORD_WIDTH-1:0]  limit_max;
   logic signed [WORD_WIDTH-1:0]  limit_min;
   logic                          input_valid;
   logic                          input_ready;
   logic [CHANNEL_ADDR_WIDTH-1:0] input_channel;
   logic                          input_load;
   logic                          input_add_sub;
   logic signed [WORD_WIDTH-1:0]  input_value;
   logic                          output_valid;
   logic                          output_ready;
   logic [CHANNEL_ADDR_WIDTH-1:0] output_channel;
   logic signed [WORD_WIDTH-1:0]  output_value;
   logic                          output_at_limit_max;
   logic                          output_over_limit_max;
   logic                          output_at_limit_min;
   logic                          output_under_limit_min;
   logic                          output_channel_error;
   logic [CHANNEL_COUNT-1:0]      saturated_sticky;

   modport slave (
      input  limit_max, limit_min,
      input  input_valid, input_channel, input_load, input_add_sub, input_value,
      output input_ready,
      output output_valid, output_channel, output_value,
      output output_at_limit_max, output_over_limit_max,
      output output_at_limit_min, output_under_limit_min,
      output output_channel_error, saturated_sticky,
      input  output_ready
   );

   modport master (
      output limit_max, limit_min,
      output input_valid, input_channel, input_load, input_add_sub, input_value,
      input  input_ready,
      input  output_valid, output_channel, output_value,
      input  output_at_limit_max, output_over_limit_max,
      input  output_at_limit_min, output_under_limit_min,
      input  output_channel_error, saturated_sticky,
      output output_ready
   );
endinterface

// File: rtl/accumulator_binary_saturating_multichannel.sv
// Multi-channel signed saturating accumulator. One accumulator flop per
// channel; each accepted command loads or adds/subtracts into its channel,
// the result is clipped to the limits sampled with the command and handed
// to a single registered output stage (latency 1, full throughput).
module accumulator_binary_saturating_multichannel #(
   parameter int WORD_WIDTH         = 16,
   parameter int CHANNEL_COUNT      = 4,
   parameter int CHANNEL_ADDR_WIDTH = 2
) (
   input logic clock,
   input logic reset_n,
   accumulator_binary_saturating_multichannel_if.slave bus
);

   logic signed [WORD_WIDTH-1:0] acc_word [CHANNEL_COUNT];
   logic [CHANNEL_COUNT-1:0]     sticky_bits;

   logic                         accept;
   logic                         channel_ok;
   logic signed [WORD_WIDTH-1:0] acc_sel;
   logic signed [WORD_WIDTH:0]   acc_ext;
   logic signed [WORD_WIDTH:0]   value_ext;
   logic signed [WORD_WIDTH:0]   max_ext;
   logic signed [WORD_WIDTH:0]   min_ext;
   logic signed [WORD_WIDTH:0]   result_ext;
   logic                         over_max;
   logic                         under_min;
   logic                         clipped;
   logic signed [WORD_WIDTH-1:0] clipped_value;

   logic                          out_valid_reg;
   logic [CHANNEL_ADDR_WIDTH-1:0] out_channel_reg;
   logic signed [WORD_WIDTH-1:0]  out_value_reg;
   logic                          out_at_max_reg;
   logic                          out_over_max_reg;
   logic                          out_at_min_reg;
   logic                          out_under_min_reg;
   logic                          out_error_reg;

   // Single output register with no skid: a new command fits whenever the
   // current result is leaving or absent. Held low while in reset.
   assign bus.input_ready = reset_n & (bus.output_ready | ~out_valid_reg);
   assign accept          = bus.input_valid & bus.input_ready;
   assign channel_ok      = (int'(bus.input_channel) < CHANNEL_COUNT);

   // Select the addressed accumulator; out-of-range channels read as zero.
   always_comb begin
      acc_sel = '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
         if (int'(bus.input_channel) == i) begin
            acc_sel = acc_word[i];
         end
      end
   end

   // One extra bit of headroom means add/sub can never wrap, so the limit
   // comparisons always see the true mathematical result.
   always_comb begin
      acc_ext   = {acc_sel[WORD_WIDTH-1], acc_sel};
      value_ext = {bus.input_value[WORD_WIDTH-1], bus.input_value};
      max_ext   = {bus.limit_max[WORD_WIDTH-1], bus.limit_max};
      min_ext   = {bus.limit_min[WORD_WIDTH-1], bus.limit_min};
      if (bus.input_load) begin
         result_ext = value_ext;
      end else if (bus.input_add_sub) begin
         result_ext = acc_ext - value_ext;
      end else begin
         result_ext = acc_ext + value_ext;
      end
      over_max  = (result_ext > max_ext);
      under_min = (result_ext < min_ext);
      clipped   = over_max | under_min;
      if (over_max) begin
         clipped_value = bus.limit_max;
      end else if (under_min) begin
         clipped_value = bus.limit_min;
      end else begin
         clipped_value = result_ext[WORD_WIDTH-1:0];
      end
   end

   // Per-channel accumulator and sticky saturation flag.
   for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_channel
      localparam logic [CHANNEL_ADDR_WIDTH-1:0] CHANNEL_INDEX = CHANNEL_ADDR_WIDTH'(gi);

      logic                         hit;
      logic signed [WORD_WIDTH-1:0] acc_reg;
      logic                         sticky_reg;

      assign hit = accept & channel_ok & (bus.input_channel == CHANNEL_INDEX);

      // Write back the clipped value; a clean load clears the sticky flag.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            acc_reg    <= '0;
            sticky_reg <= 1'b0;
         end else if (hit) begin
            acc_reg <= clipped_value;
            if (clipped) begin
               sticky_reg <= 1'b1;
            end else if (bus.input_load) begin
               sticky_reg <= 1'b0;
            end
         end
      end

      assign acc_word[gi]    = acc_reg;
      assign sticky_bits[gi] = sticky_reg;
   end

   // Output stage: reload on accept, drop valid when consumed, hold otherwise.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_reg     <= 1'b0;
         out_channel_reg   <= '0;
         out_value_reg     <= '0;
         out_at_max_reg    <= 1'b0;
         out_over_max_reg  <= 1'b0;
         out_at_min_reg    <= 1'b0;
         out_under_min_reg <= 1'b0;
         out_error_reg     <= 1'b0;
      end else if (accept) begin
         out_valid_reg     <= 1'b1;
         out_channel_reg   <= bus.input_channel;
         out_value_reg     <= channel_ok ? clipped_value : '0;
         out_at_max_reg    <= channel_ok & (result_ext == max_ext);
         out_over_max_reg  <= channel_ok & over_max;
         out_at_min_reg    <= channel_ok & (result_ext == min_ext);
         out_under_min_reg <= channel_ok & under_min;
         out_error_reg     <= ~channel_ok;
      end else if (bus.output_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.output_valid           = out_valid_reg;
   assign bus.output_channel         = out_channel_reg;
   assign bus.output_value           = out_value_reg;
   assign bus.output_at_limit_max    = out_at_max_reg;
   assign bus.output_over_limit_max  = out_over_max_reg;
   assign bus.output_at_limit_min    = out_at_min_reg;
   assign bus.output_under_limit_min = out_under_min_reg;
   assign bus.output_channel_error   = out_error_reg;
   assign bus.saturated_sticky       = sticky_bits;

endmodule
